// File: rtl/iiitb_plifo_if.sv
// rtl/iiitb_plifo_if.sv - producer/consumer bundle for the parametrised LIFO
interface iiitb_plifo_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              EN;
  logic              push;
  logic              pop;
  logic              clr_err;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;
  logic              dataValid;
  logic [DATA_W-1:0] top;
  logic [CNT_W-1:0]  count;
  logic              EMPTY;
  logic              FULL;
  logic              ALMOST_FULL;
  logic              OVF;
  logic              UDF;

  modport master (
    output EN, push, pop, clr_err, dataIn,
    input  dataOut, dataValid, top, count, EMPTY, FULL, ALMOST_FULL, OVF, UDF
  );

  modport slave (
    input  EN, push, pop, clr_err, dataIn,
    output dataOut, dataValid, top, count, EMPTY, FULL, ALMOST_FULL, OVF, UDF
  );
endinterface

// File: rtl/iiitb_plifo.sv
// rtl/iiitb_plifo.sv - parametrised LIFO with replace-top, occupancy and sticky errors
module iiitb_plifo #(
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic         Clk,
  input  logic         Rst,
  iiitb_plifo_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              ovf_q;
  logic              udf_q;

  logic              empty;
  logic              full;
  logic              pop_ok;
  logic              push_new;
  logic              dec;
  logic              wr_en;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] top_word;
  logic              ovf_set;
  logic              udf_set;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    top_idx  = AW'(count_q - 1'b1);
    top_word = mem[top_idx];
    pop_ok   = bus.EN & bus.pop & ~empty;
    // push+pop on an empty stack still grows it by one; otherwise push+pop is a replace
    push_new = bus.EN & bus.push & ~full & ~pop_ok;
    dec      = pop_ok & ~bus.push;
    wr_en    = bus.EN & bus.push & (pop_ok | ~full);
    wr_addr  = pop_ok ? top_idx : AW'(count_q);
    ovf_set  = bus.EN & bus.push & ~bus.pop & full;
    udf_set  = bus.EN & bus.pop & empty;
  end

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= bus.dataIn;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= pop_ok;
      if (pop_ok) begin
        data_out_q <= top_word;
      end
      if (push_new) begin
        count_q <= count_q + 1'b1;
      end else if (dec) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Error flags: a same-cycle error event beats clr_err
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_err) begin
        ovf_q <= 1'b0;
      end
      if (udf_set) begin
        udf_q <= 1'b1;
      end else if (bus.clr_err) begin
        udf_q <= 1'b0;
      end
    end
  end

  assign bus.dataOut     = data_out_q;
  assign bus.dataValid   = data_valid_q;
  assign bus.count       = count_q;
  assign bus.top         = empty ? '0 : top_word;
  assign bus.EMPTY       = empty;
  assign bus.FULL        = full;
  assign bus.ALMOST_FULL = (count_q >= AF_CNT);
  assign bus.OVF         = ovf_q;
  assign bus.UDF         = udf_q;
endmodule
